// File: rtl/tff_counter_n.sv
// WIDTH-bit T-flip-flop register: bitwise toggle, modulo up/down count, clamped load, wrap/saturate.
// Latency: q, tc and ovf are registered and reflect the inputs sampled at the previous rising edge.
// Backpressure: none; an operation is applied on every edge (load > en & mode).
module tff_counter_n #(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MODULUS   = 256,
    parameter int              SATURATE  = 0,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
    localparam logic             SAT     = (SATURATE != 0);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             evt;

    always_comb begin
        q_d = q_q;
        evt = 1'b0;
        if (load) begin
            q_d = (d > MAX_V) ? MAX_V : d;
        end else if (en) begin
            case (mode)
                2'b01: q_d = q_q ^ t;
                2'b10: begin
                    // a value above the range (left by a toggle) also counts as terminal
                    if (q_q >= MAX_V) begin
                        evt = 1'b1;
                        q_d = SAT ? MAX_V : '0;
                    end else begin
                        q_d = q_q + WIDTH'(1);
                    end
                end
                2'b11: begin
                    if (q_q == '0) begin
                        evt = 1'b1;
                        q_d = SAT ? '0 : MAX_V;
                    end else begin
                        q_d = q_q - WIDTH'(1);
                    end
                end
                default: q_d = q_q;
            endcase
        end
        tc_d  = evt;
        ovf_d = evt | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q_q   <= RESET_V;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_tff_counter_n.sv
// Bench for tff_counter_n: a wrapping and a saturating instance share stimulus and are
// compared each cycle against an integer-arithmetic reference of the counter rules.
module tb_tff_counter_n;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         clrn;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] t;
    logic         load;
    logic [W-1:0] d;
    logic         ovf_clr;
    logic [W-1:0] q_w, q_s;
    logic         tc_w, tc_s, ovf_w, ovf_s;

    int n_assert = 0;
    int n_fail   = 0;

    // reference state, index 0 = wrap instance, 1 = saturate instance
    int mq[2];
    int mtc[2];
    int movf[2];

    always #5 clk = ~clk;

    tff_counter_n #(.WIDTH(W), .MODULUS(MOD), .SATURATE(0), .RESET_VAL(0)) dut_w (
        .clk(clk), .clrn(clrn), .en(en), .mode(mode), .t(t), .load(load), .d(d),
        .ovf_clr(ovf_clr), .q(q_w), .tc(tc_w), .ovf(ovf_w)
    );

    tff_counter_n #(.WIDTH(W), .MODULUS(MOD), .SATURATE(1), .RESET_VAL(0)) dut_s (
        .clk(clk), .clrn(clrn), .en(en), .mode(mode), .t(t), .load(load), .d(d),
        .ovf_clr(ovf_clr), .q(q_s), .tc(tc_s), .ovf(ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("q_wrap",   q_w,   mq[0]);
        chk("tc_wrap",  tc_w,  mtc[0]);
        chk("ovf_wrap", ovf_w, movf[0]);
        chk("q_sat",    q_s,   mq[1]);
        chk("tc_sat",   tc_s,  mtc[1]);
        chk("ovf_sat",  ovf_s, movf[1]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mtc[i] = 0; movf[i] = 0;
        end
    endtask

    // Next state from the rules: load clamps, toggle ignores MODULUS, counting is mod MOD.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int nq;
            bit ev;
            nq = mq[i];
            ev = 1'b0;
            if (load) begin
                nq = (int'(d) >= MOD) ? MOD - 1 : int'(d);
            end else if (en && mode == 2'd1) begin
                nq = (mq[i] ^ int'(t)) % (1 << W);
            end else if (en && mode == 2'd2) begin
                if (mq[i] + 1 >= MOD) begin
                    ev = 1'b1;
                    nq = (i == 1) ? MOD - 1 : 0;
                end else begin
                    nq = mq[i] + 1;
                end
            end else if (en && mode == 2'd3) begin
                if (mq[i] == 0) begin
                    ev = 1'b1;
                    nq = (i == 1) ? 0 : MOD - 1;
                end else begin
                    nq = mq[i] - 1;
                end
            end
            mq[i]   = nq;
            mtc[i]  = ev ? 1 : 0;
            movf[i] = ev ? 1 : (ovf_clr ? 0 : movf[i]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic ld, input int dd, input logic e, input logic [1:0] m,
                         input int tt, input logic oc);
        load = ld; d = W'(dd); en = e; mode = m; t = W'(tt); ovf_clr = oc;
        tick();
    endtask

    // asynchronous reset pulse placed between edges
    task automatic async_reset();
        #1;
        clrn = 1'b0;
        #2;
        model_reset();
        check_all();
        clrn = 1'b1;
    endtask

    initial begin
        clrn = 1'b1; en = 1'b0; mode = 2'd0; t = '0; load = 1'b0; d = '0; ovf_clr = 1'b0;
        #2;
        clrn = 1'b0;
        #2;
        model_reset();
        check_all();
        clrn = 1'b1;
        @(posedge clk);
        #1;

        // 12 up edges: wrap gives 1..9,0,1,2 with tc after the 9->0 edge
        for (int k = 0; k < 12; k++) drive(0, 0, 1, 2'd2, 0, 0);
        chk("up12_q", q_w, 2);
        chk("up12_ovf", ovf_w, 1);

        // load 8 then up x3; saturating instance holds at 9 and re-fires tc
        drive(0, 0, 0, 2'd0, 0, 1);
        drive(1, 8, 0, 2'd0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 2'd2, 0, 0);
        chk("sat_hold_tc", tc_s, 1);

        // down from 0: wrap -> 9, saturate stays 0; both tc=1
        drive(1, 0, 0, 2'd0, 0, 0);
        drive(0, 0, 1, 2'd3, 0, 0);
        chk("down_wrap_q", q_w, 9);
        chk("down_sat_q", q_s, 0);
        drive(1, 15, 0, 2'd0, 0, 0);
        chk("load_clamp", q_w, 9);

        // toggle: 0101^0011=0110, then ^1111=1001
        drive(1, 5, 0, 2'd0, 0, 0);
        drive(0, 0, 1, 2'd1, 3, 0);
        chk("tog1", q_w, 6);
        drive(0, 0, 1, 2'd1, 15, 0);
        chk("tog2", q_w, 9);
        drive(0, 0, 1, 2'd1, 0, 0);
        drive(1, 0, 0, 2'd0, 0, 0);
        drive(0, 0, 1, 2'd1, 12, 0);
        chk("tog_out_of_range", q_w, 12);
        drive(0, 0, 1, 2'd2, 0, 0);
        chk("up_from_12", q_w, 0);
        drive(1, 0, 0, 2'd0, 0, 0);
        drive(0, 0, 1, 2'd1, 13, 0);
        drive(0, 0, 1, 2'd3, 0, 0);
        chk("down_from_13", q_w, 12);

        // load beats count; set wins over ovf_clr; ovf_clr alone clears
        drive(1, 3, 0, 2'd0, 0, 0);
        drive(1, 7, 1, 2'd2, 0, 0);
        chk("load_wins", q_w, 7);
        drive(1, 9, 0, 2'd0, 0, 0);
        drive(0, 0, 1, 2'd2, 0, 1);
        chk("set_beats_clr", ovf_w, 1);
        drive(0, 0, 0, 2'd0, 0, 1);
        chk("ovf_clr", ovf_w, 0);

        // reset mid-count at q=6, then first edge after release counts normally
        drive(1, 5, 0, 2'd0, 0, 0);
        drive(0, 0, 1, 2'd2, 0, 0);
        chk("pre_reset_q", q_w, 6);
        async_reset();
        drive(0, 0, 1, 2'd2, 0, 0);
        chk("post_reset_q", q_w, 1);

        // randomized operations with occasional loads, clears and resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) async_reset();
            drive(($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
